// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: per-channel two-flop synchroniser,
// debounce window, registered press/release strobes and auto-repeat for held buttons.
module button_conditioner #(
  parameter int   CHANNELS      = 4,
  parameter int   STABLE_CYCLES = 65535,
  parameter int   HOLD_CYCLES   = 50000000,
  parameter int   REPEAT_CYCLES = 10000000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_stb,
  output logic [CHANNELS-1:0] rpt,
  output logic [CHANNELS-1:0] held
);

  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW       = $clog2(STABLE_CYCLES);
  localparam int HW       = $clog2(HOLD_MAX);

  localparam logic [CW-1:0] STAB_LAST   = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          sync0, sync1;
    logic          lvl, lvl_next, flip;
    logic          prs, rls, rp, hld;
    logic [CW-1:0] stab_cnt;
    logic [HW-1:0] hold_cnt;

    always_comb begin
      flip     = (sync1 != lvl) && (stab_cnt == STAB_LAST);
      lvl_next = flip ? ~lvl : lvl;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync0    <= RESET_LEVEL;
        sync1    <= RESET_LEVEL;
        lvl      <= RESET_LEVEL;
        stab_cnt <= '0;
        hold_cnt <= '0;
        prs      <= 1'b0;
        rls      <= 1'b0;
        rp       <= 1'b0;
        hld      <= 1'b0;
      end else begin
        sync0 <= button[i];
        sync1 <= sync0;

        // Any sample agreeing with the current level restarts the window.
        if (sync1 == lvl) begin
          stab_cnt <= '0;
        end else if (flip) begin
          stab_cnt <= '0;
          lvl      <= ~lvl;
        end else begin
          stab_cnt <= stab_cnt + CW'(1);
        end

        prs <= flip && (lvl == RESET_LEVEL);
        rls <= flip && (lvl != RESET_LEVEL);
        rp  <= 1'b0;

        // Idle, press and release cycles all leave the hold state cleared;
        // the counter reloads per interval once held, so it never overflows.
        if ((lvl == RESET_LEVEL) || (lvl_next == RESET_LEVEL)) begin
          hold_cnt <= '0;
          hld      <= 1'b0;
        end else if (!hld) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            hld      <= 1'b1;
            rp       <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end else begin
          if (hold_cnt == REPEAT_LAST) begin
            hold_cnt <= '0;
            rp       <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
      end
    end

    assign level[i]       = lvl;
    assign press[i]       = prs;
    assign release_stb[i] = rls;
    assign rpt[i]         = rp;
    assign held[i]        = hld;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (2 channels, window 4, hold 8, repeat 3).
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] button;
  logic [1:0] level, press, release_stb, rpt, held;

  int checks   = 0;
  int failures = 0;

  button_conditioner #(
    .CHANNELS(2), .STABLE_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(3), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .level(level), .press(press),
    .release_stb(release_stb), .rpt(rpt), .held(held)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got={lvl,prs,rel,rpt,hld}=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] lv, input logic [1:0] pr,
                            input logic [1:0] rl, input logic [1:0] rp, input logic [1:0] hd);
    check(tag, {level, press, release_stb, rpt, held}, {lv, pr, rl, rp, hd});
  endtask

  // advance n posedges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    button = 2'b11;
    tick(3);
    expect_out("reset_idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // buttons held through reset release: fresh press 5 edges after first sample
    rst = 1'b0;
    tick(5);
    expect_out("rst_press_k4", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    expect_out("rst_press_k5", 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    tick(1);
    expect_out("rst_press_k6", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    button = 2'b00;
    tick(5);
    expect_out("rel_before", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    expect_out("rel_edge", 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    tick(1);
    expect_out("rel_after", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // bounce on channel 0: 3-cycle pulses never qualify
    for (int s = 0; s < 4; s++) begin
      button = (s % 2 == 0) ? 2'b01 : 2'b00;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        expect_out($sformatf("bounce_s%0d_c%0d", s, j), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      end
    end
    button = 2'b00;
    for (int j = 0; j < 8; j++) begin
      tick(1);
      expect_out($sformatf("bounce_settle_%0d", j), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // hold/repeat then release on channel 1 (press edge p; drop sampled at p+17)
    button = 2'b10;
    tick(5);
    expect_out("hold_pre", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    expect_out("hold_press", 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    for (int d = 1; d <= 26; d++) begin
      logic lv1, rl1, hd1, rp1;
      tick(1);
      lv1 = (d < 22);
      rl1 = (d == 22);
      hd1 = (d >= 8) && (d < 22);
      rp1 = hd1 && ((d - 8) % 3 == 0);
      expect_out($sformatf("hold_d%0d", d), {lv1, 1'b0}, 2'b00, {rl1, 1'b0}, {rp1, 1'b0}, {hd1, 1'b0});
      if (d == 16) button = 2'b00;
    end

    // simultaneous press; channel 0 released mid-hold of channel 1
    button = 2'b11;
    tick(5);
    expect_out("sim_pre", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    expect_out("sim_press", 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int d = 1; d <= 15; d++) begin
      logic lv0, rl0, hd1, rp1;
      tick(1);
      lv0 = (d < 8);
      rl0 = (d == 8);
      hd1 = (d >= 8);
      rp1 = hd1 && ((d - 8) % 3 == 0);
      expect_out($sformatf("sim_d%0d", d), {1'b1, lv0}, 2'b00, {1'b0, rl0}, {rp1, 1'b0}, {hd1, 1'b0});
      if (d == 2) button = 2'b10;
    end
    button = 2'b00;
    tick(10);
    expect_out("sim_idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // reset two cycles before the first expected repeat
    button = 2'b10;
    tick(6);
    expect_out("mid_press", 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    tick(5);
    expect_out("mid_p5", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    #1;
    expect_out("mid_rst_async", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int j = 0; j < 4; j++) begin
      tick(1);
      expect_out($sformatf("mid_rst_c%0d", j), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b0;
    tick(5);
    expect_out("re_pre", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(1);
    expect_out("re_press", 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    for (int d = 1; d <= 9; d++) begin
      logic hd1, rp1;
      tick(1);
      hd1 = (d >= 8);
      rp1 = (d == 8);
      expect_out($sformatf("re_d%0d", d), 2'b10, 2'b00, 2'b00, {rp1, 1'b0}, {hd1, 1'b0});
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
